// File: rtl/lii_out_arbiter.sv
// Round-robin arbiter sharing one LII output channel among N requesters.
// Optional feature macro: LII_ARB_BURST_EN (multi-beat bursts; otherwise one beat per grant).
module lii_out_arbiter #(
  parameter int N     = 4,
  parameter int PW    = 1024,
  parameter int BURST = 16
) (
  input  logic                 aclk,
  input  logic                 arst,
  input  logic [N*PW-1:0]      req_tdata,
  input  logic [N-1:0]         req_tvalid,
  output logic [N-1:0]         req_tready,
  input  logic [N*8-1:0]       req_src,
  input  logic [N*8-1:0]       req_dst,
  output logic [PW-1:0]        lii_out_p0_tdata,
  output logic                 lii_out_p0_tvalid,
  input  logic                 lii_out_p0_tready,
  output logic [7:0]           lii_out_p0_src,
  output logic [7:0]           lii_out_p0_dst,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy
);

  // state   | meaning
  // S_IDLE  | no owner; pick next requester at or after rr_ptr
  // S_GRANT | grant_id owns the channel; outputs are a pass-through mux
  localparam int GW = $clog2(N);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]    state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] sel_id;
  logic          sel_vld;
  logic [GW-1:0] next_rr;
  logic          own_vld;
  logic          hs;
  logic          last_beat;
  logic          release_g;

  // Scan downward so the lowest offset from rr_ptr is the one left standing.
  always_comb begin
    logic [GW:0] sum;
    sel_id  = '0;
    sel_vld = 1'b0;
    sum     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (GW+1)'(k);
      if (sum >= (GW+1)'(N)) sum = sum - (GW+1)'(N);
      if (req_tvalid[sum[GW-1:0]]) begin
        sel_id  = sum[GW-1:0];
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    lii_out_p0_tdata  = '0;
    lii_out_p0_tvalid = 1'b0;
    lii_out_p0_src    = '0;
    lii_out_p0_dst    = '0;
    req_tready        = '0;
    for (int i = 0; i < N; i++) begin
      if (state == S_GRANT && grant_id == GW'(i)) begin
        lii_out_p0_tdata  = req_tdata[i*PW +: PW];
        lii_out_p0_tvalid = req_tvalid[i];
        lii_out_p0_src    = req_src[i*8 +: 8];
        lii_out_p0_dst    = req_dst[i*8 +: 8];
        req_tready[i]     = lii_out_p0_tready;
      end
    end
  end

  assign busy      = (state == S_GRANT);
  assign own_vld   = req_tvalid[grant_id];
  assign hs        = lii_out_p0_tvalid & lii_out_p0_tready;
  assign next_rr   = (grant_id == GW'(N - 1)) ? '0 : grant_id + 1'b1;
  assign release_g = busy && ((hs && last_beat) || !own_vld);

`ifdef LII_ARB_BURST_EN
  localparam int BW = $clog2(BURST + 1);
  logic [BW-1:0] beat_cnt;

  assign last_beat = (beat_cnt == BW'(BURST - 1));

  // Cleared on every new grant; release at BURST-1 keeps it from wrapping.
  always_ff @(posedge aclk) begin
    if (arst) begin
      beat_cnt <= '0;
    end else if (state == S_IDLE) begin
      beat_cnt <= '0;
    end else if (hs && !release_g) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end
`else
  assign last_beat = 1'b1;
`endif

  always_ff @(posedge aclk) begin
    if (arst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_vld) begin
            grant_id <= sel_id;
            state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (release_g) begin
            rr_ptr <= next_rr;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lii_out_arbiter.sv
// Directed self-checking bench for lii_out_arbiter (N=4, PW=32, BURST=16).
// Expectations follow whichever LII_ARB_BURST_EN setting the design was built with.
module tb_lii_out_arbiter;
  localparam int N = 4;
  localparam int PW = 32;
  localparam int BURST = 16;

  logic            aclk = 1'b0;
  logic            arst;
  logic [N*PW-1:0] req_tdata;
  logic [N-1:0]    req_tvalid;
  logic [N-1:0]    req_tready;
  logic [N*8-1:0]  req_src;
  logic [N*8-1:0]  req_dst;
  logic [PW-1:0]   lii_out_p0_tdata;
  logic            lii_out_p0_tvalid;
  logic            lii_out_p0_tready;
  logic [7:0]      lii_out_p0_src;
  logic [7:0]      lii_out_p0_dst;
  logic [1:0]      grant_id;
  logic            busy;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  lii_out_arbiter #(.N(N), .PW(PW), .BURST(BURST)) dut (
    .aclk(aclk), .arst(arst),
    .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tready(req_tready),
    .req_src(req_src), .req_dst(req_dst),
    .lii_out_p0_tdata(lii_out_p0_tdata), .lii_out_p0_tvalid(lii_out_p0_tvalid),
    .lii_out_p0_tready(lii_out_p0_tready),
    .lii_out_p0_src(lii_out_p0_src), .lii_out_p0_dst(lii_out_p0_dst),
    .grant_id(grant_id), .busy(busy)
  );

  function automatic logic [PW-1:0] data_of(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h111;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  // Compares every output against the pass-through of requester gid (or idle).
  task automatic expect_state(input string tag, input bit busy_e, input int gid);
    logic [PW-1:0] d_e;
    logic [7:0]    s_e, t_e;
    logic [N-1:0]  r_e;
    logic          v_e;
    #1;
    d_e = '0; s_e = '0; t_e = '0; r_e = '0; v_e = 1'b0;
    if (busy_e) begin
      v_e = req_tvalid[gid];
      d_e = data_of(gid);
      s_e = 8'h10 + 8'(gid);
      t_e = 8'h20 + 8'(gid);
      r_e = lii_out_p0_tready ? (N'(1) << gid) : '0;
    end
    check_val({tag, ".busy"}, 64'(busy), 64'(busy_e));
    if (busy_e) check_val({tag, ".grant_id"}, 64'(grant_id), 64'(gid));
    check_val({tag, ".tvalid"}, 64'(lii_out_p0_tvalid), 64'(v_e));
    check_val({tag, ".req_tready"}, 64'(req_tready), 64'(r_e));
    check_val({tag, ".tdata"}, 64'(lii_out_p0_tdata), 64'(d_e));
    check_val({tag, ".src"}, 64'(lii_out_p0_src), 64'(s_e));
    check_val({tag, ".dst"}, 64'(lii_out_p0_dst), 64'(t_e));
  endtask

  task automatic do_reset();
    arst = 1'b1;
    tick(); tick(); tick();
    arst = 1'b0;
  endtask

  // Step one cycle per entry; -1 means an idle bubble.
  task automatic run_seq(input string tag, input int ids[8], input int len);
    for (int c = 0; c < len; c++) begin
      tick();
      expect_state($sformatf("%s[%0d]", tag, c), ids[c] >= 0, (ids[c] < 0) ? 0 : ids[c]);
    end
  endtask

  initial begin
    int seq[8];
    int hs_cnt;
    int cyc;
    bit pat[4];

    for (int i = 0; i < N; i++) begin
      req_tdata[i*PW +: PW] = data_of(i);
      req_src[i*8 +: 8]     = 8'h10 + 8'(i);
      req_dst[i*8 +: 8]     = 8'h20 + 8'(i);
    end
    req_tvalid        = '1;
    lii_out_p0_tready = 1'b1;
    arst              = 1'b1;

    for (int c = 0; c < 3; c++) begin
      tick();
      expect_state($sformatf("rst[%0d]", c), 1'b0, 0);
      check_val($sformatf("rst[%0d].grant_id", c), 64'(grant_id), 64'd0);
    end
    arst = 1'b0;
    tick();
    expect_state("rst_first", 1'b1, 0);

`ifdef LII_ARB_BURST_EN
    req_tvalid = 4'b0100;
    do_reset();
    for (int b = 0; b < BURST; b++) begin
      tick();
      expect_state($sformatf("burst2[%0d]", b), 1'b1, 2);
    end
    tick(); expect_state("burst2_bubble", 1'b0, 0);
    tick(); expect_state("burst2_again", 1'b1, 2);

    req_tvalid = 4'b1111;
    do_reset();
    seq = '{0, 1, 2, 3, 0, 0, 0, 0};
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < BURST; b++) begin
        tick();
        expect_state($sformatf("rr_g%0d[%0d]", g, b), 1'b1, seq[g]);
      end
      if (g < 4) begin
        tick();
        expect_state($sformatf("rr_bubble%0d", g), 1'b0, 0);
      end
    end

    req_tvalid = 4'b0010;
    do_reset();
    tick();
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    hs_cnt = 0;
    cyc = 0;
    while (hs_cnt < BURST && cyc < 100) begin
      lii_out_p0_tready = pat[cyc % 4];
      expect_state($sformatf("bp[%0d]", cyc), 1'b1, 1);
      if (lii_out_p0_tready) hs_cnt++;
      cyc++;
      tick();
    end
    check_val("bp_handshakes", 64'(hs_cnt), 64'(BURST));
    expect_state("bp_released", 1'b0, 0);
    lii_out_p0_tready = 1'b1;

    req_tvalid = 4'b1001;
    do_reset();
    for (int b = 0; b < 5; b++) begin
      tick();
      expect_state($sformatf("early0[%0d]", b), 1'b1, 0);
    end
    tick();
    req_tvalid = 4'b1000;
    expect_state("early_drop", 1'b1, 0);
    tick(); expect_state("early_bubble", 1'b0, 0);
    tick(); expect_state("early_grant3", 1'b1, 3);
`else
    req_tvalid = 4'b0011;
    do_reset();
    seq = '{0, -1, 1, -1, 0, -1, 1, -1};
    run_seq("alt", seq, 8);

    req_tvalid = 4'b1111;
    do_reset();
    seq = '{0, -1, 1, -1, 2, -1, 3, -1};
    run_seq("rr", seq, 8);
    tick(); expect_state("rr_wrap", 1'b1, 0);

    req_tvalid = 4'b0100;
    lii_out_p0_tready = 1'b0;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      expect_state($sformatf("stall[%0d]", c), 1'b1, 2);
    end
    lii_out_p0_tready = 1'b1;
    expect_state("stall_ready", 1'b1, 2);
    tick(); expect_state("stall_release", 1'b0, 0);
    tick(); expect_state("stall_regrant", 1'b1, 2);

    lii_out_p0_tready = 1'b0;
    req_tvalid = 4'b1000;
    expect_state("drop_owner", 1'b1, 2);
    tick(); expect_state("drop_bubble", 1'b0, 0);
    tick(); expect_state("drop_grant3", 1'b1, 3);

    req_tvalid = 4'b1001;
    lii_out_p0_tready = 1'b1;
    seq = '{-1, 0, -1, 3, -1, 0, 0, 0};
    run_seq("lowprio", seq, 6);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
